// File: rtl/ult_meas_ctrl.sv
// ---------------------------------------------------------------------------
// ult_meas_ctrl
//
// Purpose:
//   Controller for an HC-SR04 style ultrasonic ranger. While en is high it
//   fires a trigger pulse once every measurement period. It then times the
//   echo pulse in centimetre units and reports the distance. A missing echo
//   or an echo that stays high too long is reported as an error.
//
// Parameters:
//   CLK_MHZ    clock frequency in MHz
//   TRIG_US    trigger pulse width in us
//   PERIOD_MS  measurement repetition period in ms
//   TMO_MS     echo wait / echo high timeout in ms
//   US_PER_CM  round-trip echo time per cm in us
//
// Ports:
//   clk       in   system clock (single domain)
//   rstn      in   asynchronous active-low reset
//   en        in   1 = run continuous measurement cycles
//   echo      in   sensor echo, asynchronous to clk
//   trig      out  sensor trigger pulse (registered)
//   dist_cm   out  last valid distance in cm, held between updates
//   dist_vld  out  one-cycle pulse when dist_cm updates
//   err       out  last cycle timed out; held until next valid result
//   busy      out  high whenever the controller is not idle
// ---------------------------------------------------------------------------
module ult_meas_ctrl #(
  parameter int CLK_MHZ   = 12,
  parameter int TRIG_US   = 10,
  parameter int PERIOD_MS = 60,
  parameter int TMO_MS    = 30,
  parameter int US_PER_CM = 58
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       echo,
  output logic       trig,
  output logic [9:0] dist_cm,
  output logic       dist_vld,
  output logic       err,
  output logic       busy
);

  localparam int TRIG_CYC   = CLK_MHZ * TRIG_US;
  localparam int PERIOD_CYC = CLK_MHZ * 1000 * PERIOD_MS;
  localparam int TMO_CYC    = CLK_MHZ * 1000 * TMO_MS;
  localparam int CM_CYC     = CLK_MHZ * US_PER_CM;

  // The period counter can run past PERIOD_CYC when the timeouts add up to
  // more than one period, so size it for the longest possible cycle.
  localparam int LONGEST_CYC = TRIG_CYC + 2 * TMO_CYC + 2;
  localparam int PER_MAX     = (PERIOD_CYC > LONGEST_CYC) ? PERIOD_CYC : LONGEST_CYC;
  localparam int PER_W       = $clog2(PER_MAX + 1);
  localparam int TMO_W       = $clog2(TMO_CYC + 1);
  localparam int PRE_W       = $clog2(CM_CYC + 1);

  localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_CYC - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CM_CYC - 1);

  // The clock on which the rising edge is seen already has echo_s high. It
  // is counted as the first high clock so that an echo high for N clocks
  // measures exactly N clocks.
  localparam logic [PRE_W-1:0] PRE_FIRST = (CM_CYC == 1) ? PRE_W'(0) : PRE_W'(1);
  localparam logic [9:0]       CM_FIRST  = (CM_CYC == 1) ? 10'd1 : 10'd0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t           state_q;
  logic [PER_W-1:0] per_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic [9:0]       cm_cnt_q;

  logic             echo_meta_q;
  logic             echo_s_q;
  logic             echo_prev_q;

  logic             trig_q;
  logic [9:0]       dist_cm_q;
  logic             dist_vld_q;
  logic             err_q;
  logic             busy_q;

  logic             echo_rise_d;
  logic             echo_fall_d;
  logic [9:0]       cm_inc_d;

  assign echo_rise_d = echo_s_q & ~echo_prev_q;
  assign echo_fall_d = ~echo_s_q & echo_prev_q;
  assign cm_inc_d    = (cm_cnt_q == 10'd1023) ? cm_cnt_q : cm_cnt_q + 10'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      per_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      cm_cnt_q    <= '0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
      trig_q      <= 1'b0;
      dist_cm_q   <= '0;
      dist_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
      dist_vld_q  <= 1'b0;

      // Free-running period timebase; cleared below on every entry to S_TRIG.
      if (state_q != S_IDLE) begin
        per_cnt_q <= per_cnt_q + PER_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q   <= S_TRIG;
            trig_q    <= 1'b1;
            busy_q    <= 1'b1;
            per_cnt_q <= '0;
          end
        end

        // The period counter doubles as the trigger width timer.
        S_TRIG: begin
          if (per_cnt_q == TRIG_LAST) begin
            state_q   <= S_WAIT_RISE;
            trig_q    <= 1'b0;
            tmo_cnt_q <= '0;
          end
        end

        // Only a genuine 0->1 transition starts a measurement; an echo that
        // is already high on entry never produces echo_rise_d.
        S_WAIT_RISE: begin
          if (echo_rise_d) begin
            state_q   <= S_MEASURE;
            tmo_cnt_q <= TMO_W'(1);
            pre_cnt_q <= PRE_FIRST;
            cm_cnt_q  <= CM_FIRST;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= S_HOLD;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end

        // Without a falling edge echo_s is necessarily still high here, so
        // every non-falling cycle is a counted high clock.
        S_MEASURE: begin
          if (echo_fall_d) begin
            state_q    <= S_HOLD;
            dist_cm_q  <= cm_cnt_q;
            dist_vld_q <= 1'b1;
            err_q      <= 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= S_HOLD;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (pre_cnt_q == PRE_LAST) begin
              pre_cnt_q <= '0;
              cm_cnt_q  <= cm_inc_d;
            end else begin
              pre_cnt_q <= pre_cnt_q + PRE_W'(1);
            end
          end
        end

        // The >= comparison covers configurations where a timed-out cycle
        // is already past the nominal period on arrival.
        S_HOLD: begin
          if (per_cnt_q >= PER_LAST) begin
            if (en) begin
              state_q   <= S_TRIG;
              trig_q    <= 1'b1;
              per_cnt_q <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig     = trig_q;
  assign dist_cm  = dist_cm_q;
  assign dist_vld = dist_vld_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule
